mips_load_store_unit: RTL and testbench

Initiator side of the mini-MIPS data-memory port: accepts one load/store request at a time from the MEM stage and drives the word-addressed data memory's address, write_data, mem_read and mem_write signals. It turns byte-addressed MIPS loads and stores (lb/lbu/lh/lhu/lw/sb/sh/sw) into word accesses. Sub-word stores are performed as read-modify-write, and loads are sign- or zero-extended. Misaligned, out-of-range or unknown requests are rejected without touching memory.

---
 rtl/mips_lsu_pkg.sv | 76 +++++++
 rtl/mips_load_store_unit_lane.sv | 19 +
 rtl/mips_load_store_unit.sv | 124 ++++++++++++
 tb/tb_mips_load_store_unit.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_lsu_pkg.sv
// Shared opcodes, FSM states and lane helpers for the mini-MIPS load/store unit.
package mips_lsu_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Loads sit at 0x20-0x25, stores at 0x28-0x2B: bit 3 tells them apart.
    function automatic logic is_load(input logic [5:0] op);
        return !op[3];
    endfunction

    // Select the big-endian byte/halfword lane and extend it to 32 bits.
    function automatic logic [31:0] lane_extract(input logic [5:0]  op,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (op)
            OP_LB:   res = {{24{b[7]}}, b};
            OP_LBU:  res = {24'd0, b};
            OP_LH:   res = {{16{h[15]}}, h};
            OP_LHU:  res = {16'd0, h};
            OP_LW:   res = word;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Insert the low byte/halfword of the store data into the fetched word.
    function automatic logic [31:0] lane_merge(input logic [5:0]  op,
                                               input logic [1:0]  off,
                                               input logic [31:0] word,
                                               input logic [31:0] wdata);
        logic [31:0] res;
        res = word;
        case (op)
            OP_SB: begin
                case (off)
                    2'd0:    res[31:24] = wdata[7:0];
                    2'd1:    res[23:16] = wdata[7:0];
                    2'd2:    res[15:8]  = wdata[7:0];
                    default: res[7:0]   = wdata[7:0];
                endcase
            end
            OP_SH: begin
                if (off[1]) res[15:0]  = wdata[15:0];
                else        res[31:16] = wdata[15:0];
            end
            OP_SW:   res = wdata;
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mips_load_store_unit_lane.sv
// Combinational lane logic: load extraction/extension and sub-word store merge.
module mips_lsu_lane
    import mips_lsu_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data_c,
    output logic [31:0] merge_word_c
);

    // Both results derive from the word currently returned by memory.
    always_comb begin
        load_data_c  = lane_extract(op, offset, rd_word);
        merge_word_c = lane_merge(op, offset, rd_word, wdata);
    end

endmodule

// File: rtl/mips_load_store_unit.sv
// Data-memory initiator: byte-addressed MIPS loads/stores onto a word memory.
module mips_load_store_unit
    import mips_lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    localparam int unsigned ADDR_LIMIT = 4 * MEM_WORDS;

    lsu_state_e  state;
    logic [5:0]  op_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data_c;
    logic [31:0] merge_word_c;
    logic        req_err_c;
    logic        accept_c;

    mips_lsu_lane u_lane (
        .op          (op_q),
        .offset      (off_q),
        .rd_word     (mem_read_data),
        .wdata       (wdata_q),
        .load_data_c (load_data_c),
        .merge_word_c(merge_word_c)
    );

    // Ready follows reset release directly so a request can be taken in that cycle.
    assign req_ready = rst_n && (state == ST_IDLE);
    assign accept_c  = req_valid && req_ready;

    // Reject unknown opcodes, misaligned accesses and addresses past the memory.
    always_comb begin
        req_err_c = 1'b0;
        case (req_op)
            OP_LB, OP_LBU, OP_SB: req_err_c = 1'b0;
            OP_LH, OP_LHU, OP_SH: req_err_c = req_addr[0];
            OP_LW, OP_SW:         req_err_c = (req_addr[1:0] != 2'd0);
            default:              req_err_c = 1'b1;
        endcase
        if (req_addr >= 32'(ADDR_LIMIT)) req_err_c = 1'b1;
    end

    // Request FSM with registered memory and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            op_q           <= 6'd0;
            off_q          <= 2'd0;
            wdata_q        <= 32'd0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'd0;
            resp_err       <= 1'b0;
            mem_address    <= 32'd0;
            mem_write_data <= 32'd0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        op_q    <= req_op;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        if (req_err_c) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_op == OP_SW) begin
                            state          <= ST_WRITE;
                            mem_write      <= 1'b1;
                            mem_address    <= {2'b00, req_addr[31:2]};
                            mem_write_data <= req_wdata;
                        end else begin
                            state       <= ST_READ;
                            mem_read    <= 1'b1;
                            mem_address <= {2'b00, req_addr[31:2]};
                        end
                    end
                end
                ST_READ: begin
                    if (is_load(op_q)) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data_c;
                    end else begin
                        state          <= ST_WRITE;
                        mem_write      <= 1'b1;
                        mem_write_data <= merge_word_c;
                    end
                end
                ST_WRITE: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Self-checking bench for mips_load_store_unit with a behavioural word memory.
module tb_mips_load_store_unit;

    localparam logic [5:0] T_LB  = 6'h20;
    localparam logic [5:0] T_LH  = 6'h21;
    localparam logic [5:0] T_LW  = 6'h23;
    localparam logic [5:0] T_LBU = 6'h24;
    localparam logic [5:0] T_LHU = 6'h25;
    localparam logic [5:0] T_SB  = 6'h28;
    localparam logic [5:0] T_SH  = 6'h29;
    localparam logic [5:0] T_SW  = 6'h2B;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mem  [0:255];
    logic [31:0] gold [0:255];
    int          cyc;
    int          n_cmp;
    int          n_fail;
    int          rd_cnt;
    int          wr_cnt;
    logic        overlap;

    mips_load_store_unit #(.MEM_WORDS(256)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_read_data (mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[7:0]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_address[7:0]] <= mem_write_data;
        if (mem_read) rd_cnt <= rd_cnt + 1;
        if (mem_write) wr_cnt <= wr_cnt + 1;
        if (mem_read && mem_write) overlap <= 1'b1;
        cyc <= cyc + 1;
    end

    // Scoreboard: every response must match the oldest expectation, in the expected cycle.
    always @(posedge clk) begin
        #1;
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_resp: got rdata=%h err=%b at cycle %0d, required no response",
                         resp_rdata, resp_err, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                n_cmp++;
                if ({resp_rdata, resp_err} !== {mon_e.rdata, mon_e.err}) begin
                    n_fail++;
                    $display("FAIL resp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                             resp_rdata, resp_err, mon_e.rdata, mon_e.err);
                end
                n_cmp++;
                if (cyc !== mon_e.cyc) begin
                    n_fail++;
                    $display("FAIL resp_latency: got cycle %0d, required cycle %0d", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic set_word(input int idx, input logic [31:0] val);
        mem[idx]  = val;
        gold[idx] = val;
    endtask

    // Present a request once the unit is ready; returns before the accept edge.
    task automatic send(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        if (!req_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL ready_timeout: got req_ready=0, required 1 within 20 cycles");
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    task automatic expect_resp(input logic [31:0] rdata, input logic err, input int lat);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.cyc   = cyc + lat;
        sb_q.push_back(e);
    endtask

    // Pass the accept edge, then scramble the request inputs.
    task automatic accept_edge();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 6'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL resp_timeout: got %0d outstanding responses, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr);
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] r;
        w = gold[addr[9:2]];
        b = (w >> (8 * (3 - int'(addr[1:0])))) & 32'h0000_00FF;
        h = (w >> (16 * (1 - int'(addr[1])))) & 32'h0000_FFFF;
        case (op)
            T_LB:    r = b[7]  ? (b | 32'hFFFF_FF00) : b;
            T_LBU:   r = b;
            T_LH:    r = h[15] ? (h | 32'hFFFF_0000) : h;
            T_LHU:   r = h;
            default: r = w;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready/rv/err/rd/wr=%b, required 00000",
                     {req_ready, resp_valid, resp_err, mem_read, mem_write});
        end
        n_cmp++;
        if ({resp_rdata, mem_address, mem_write_data} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h, required all 0",
                     resp_rdata, mem_address, mem_write_data);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_lw();
        set_word(4, 32'hDEADBEEF);
        send(T_LW, 32'h10, 32'h0);
        expect_resp(32'hDEADBEEF, 1'b0, 2);
        accept_edge();
        n_cmp++;
        if ({req_ready, mem_read, mem_write} !== 3'b010) begin
            n_fail++;
            $display("FAIL lw_cycle1_ctrl: got ready/rd/wr=%b, required 010",
                     {req_ready, mem_read, mem_write});
        end
        n_cmp++;
        if (mem_address !== 32'd4) begin
            n_fail++;
            $display("FAIL lw_address: got %h, required 00000004", mem_address);
        end
        drain();
    endtask

    task automatic test_subword_loads();
        logic [5:0]  ops  [0:7];
        logic [31:0] addrs[0:7];
        logic [31:0] exps [0:7];
        set_word(4, 32'h12F45678);
        set_word(5, 32'h8001ABCD);
        ops[0] = T_LB;  addrs[0] = 32'h11; exps[0] = 32'hFFFFFFF4;
        ops[1] = T_LBU; addrs[1] = 32'h11; exps[1] = 32'h000000F4;
        ops[2] = T_LH;  addrs[2] = 32'h12; exps[2] = 32'h00005678;
        ops[3] = T_LHU; addrs[3] = 32'h10; exps[3] = 32'h000012F4;
        ops[4] = T_LH;  addrs[4] = 32'h14; exps[4] = 32'hFFFF8001;
        ops[5] = T_LB;  addrs[5] = 32'h17; exps[5] = 32'hFFFFFFCD;
        ops[6] = T_LHU; addrs[6] = 32'h16; exps[6] = 32'h0000ABCD;
        ops[7] = T_LBU; addrs[7] = 32'h14; exps[7] = 32'h00000080;
        for (int i = 0; i < 8; i++) begin
            send(ops[i], addrs[i], 32'hFFFF_FFFF);
            expect_resp(exps[i], 1'b0, 2);
            accept_edge();
            drain();
        end
    endtask

    task automatic test_sub_store();
        set_word(4, 32'h11223344);
        send(T_SB, 32'h13, 32'hFFFF_FFAA);
        expect_resp(32'd0, 1'b0, 3);
        accept_edge();
        n_cmp++;
        if ({mem_read, mem_write, mem_address} !== {2'b10, 32'd4}) begin
            n_fail++;
            $display("FAIL sb_read_phase: got rd/wr=%b addr=%h, required 10 addr=00000004",
                     {mem_read, mem_write}, mem_address);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({mem_read, mem_write, mem_write_data} !== {2'b01, 32'h112233AA}) begin
            n_fail++;
            $display("FAIL sb_write_phase: got rd/wr=%b wdata=%h, required 01 wdata=112233AA",
                     {mem_read, mem_write}, mem_write_data);
        end
        drain();
        n_cmp++;
        if (mem[4] !== 32'h112233AA) begin
            n_fail++;
            $display("FAIL sb_mem: got %h, required 112233AA", mem[4]);
        end
        gold[4] = 32'h112233AA;
        send(T_SH, 32'h10, 32'h1234_BEEF);
        expect_resp(32'd0, 1'b0, 3);
        accept_edge();
        drain();
        n_cmp++;
        if (mem[4] !== 32'hBEEF33AA) begin
            n_fail++;
            $display("FAIL sh_mem: got %h, required BEEF33AA", mem[4]);
        end
        gold[4] = 32'hBEEF33AA;
    endtask

    task automatic test_sw();
        int wr0;
        wr0 = wr_cnt;
        send(T_SW, 32'h20, 32'hCAFEBABE);
        expect_resp(32'd0, 1'b0, 2);
        accept_edge();
        n_cmp++;
        if ({mem_read, mem_write, mem_address, mem_write_data} !== {2'b01, 32'd8, 32'hCAFEBABE}) begin
            n_fail++;
            $display("FAIL sw_write: got rd/wr=%b addr=%h wdata=%h, required 01 00000008 CAFEBABE",
                     {mem_read, mem_write}, mem_address, mem_write_data);
        end
        drain();
        n_cmp++;
        if (wr_cnt - wr0 !== 1) begin
            n_fail++;
            $display("FAIL sw_write_count: got %0d write cycles, required 1", wr_cnt - wr0);
        end
        gold[8] = 32'hCAFEBABE;
        send(T_LW, 32'h20, 32'h0);
        expect_resp(32'hCAFEBABE, 1'b0, 2);
        accept_edge();
        drain();
    endtask

    task automatic test_errors();
        logic [5:0]  ops  [0:5];
        logic [31:0] addrs[0:5];
        int rd0;
        int wr0;
        ops[0] = T_LW;  addrs[0] = 32'h002;
        ops[1] = T_SH;  addrs[1] = 32'h005;
        ops[2] = T_LW;  addrs[2] = 32'h400;
        ops[3] = 6'h22; addrs[3] = 32'h010;
        ops[4] = T_SB;  addrs[4] = 32'h400;
        ops[5] = T_LHU; addrs[5] = 32'h3FF;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        for (int i = 0; i < 6; i++) begin
            send(ops[i], addrs[i], 32'h5555_5555);
            expect_resp(32'd0, 1'b1, 1);
            accept_edge();
            drain();
        end
        n_cmp++;
        if ((rd_cnt !== rd0) || (wr_cnt !== wr0)) begin
            n_fail++;
            $display("FAIL err_mem_touch: got %0d reads %0d writes, required 0 0",
                     rd_cnt - rd0, wr_cnt - wr0);
        end
        set_word(255, 32'h0BADF00D);
        send(T_LW, 32'h3FC, 32'h0);
        expect_resp(32'h0BADF00D, 1'b0, 2);
        accept_edge();
        drain();
        send(T_LBU, 32'h3FF, 32'h0);
        expect_resp(32'h0000000D, 1'b0, 2);
        accept_edge();
        drain();
    endtask

    // Requests issued as soon as ready, mixing random loads and word stores.
    task automatic test_back_to_back();
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       op = T_LB;
                1:       op = T_LBU;
                2:       op = T_LH;
                3:       op = T_LHU;
                4:       op = T_LW;
                default: op = T_SW;
            endcase
            addr = 32'($urandom_range(0, 63));
            if (op == T_LW || op == T_SW) addr[1:0] = 2'b00;
            if (op == T_LH || op == T_LHU) addr[0] = 1'b0;
            wd = $urandom;
            send(op, addr, wd);
            if (op == T_SW) begin
                expect_resp(32'd0, 1'b0, 2);
                gold[addr[9:2]] = wd;
            end else begin
                expect_resp(model_load(op, addr), 1'b0, 2);
            end
            accept_edge();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        set_word(6, 32'h55667788);
        send(T_SH, 32'h18, 32'h0000BEEF);
        accept_edge();
        @(posedge clk); #1;
        n_cmp++;
        if (mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_write: got mem_write=%b, required 1", mem_write);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, resp_valid, mem_read, mem_write, mem_address, mem_write_data} !== 68'd0) begin
            n_fail++;
            $display("FAIL rst_async_drop: got ready/rv/rd/wr=%b addr=%h wdata=%h, required all 0",
                     {req_ready, resp_valid, mem_read, mem_write}, mem_address, mem_write_data);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (mem[6] !== 32'h55667788) begin
            n_fail++;
            $display("FAIL rst_no_write: got %h, required 55667788", mem[6]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_ready: got %b, required 1", req_ready);
        end
        repeat (3) @(negedge clk);
        send(T_LW, 32'h18, 32'h0);
        expect_resp(32'h55667788, 1'b0, 2);
        accept_edge();
        drain();
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 6'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        cyc       = 0;
        n_cmp     = 0;
        n_fail    = 0;
        rd_cnt    = 0;
        wr_cnt    = 0;
        overlap   = 1'b0;
        for (int i = 0; i < 256; i++) set_word(i, 32'h0101_0101 * i);

        test_reset();
        test_lw();
        test_subword_loads();
        test_sub_store();
        test_sw();
        test_errors();
        test_back_to_back();
        test_reset_mid();

        n_cmp++;
        if (overlap !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_wr_overlap: got mem_read and mem_write together, required never");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
